// File: rtl/joy_hex_encoder.sv
// joy_hex_encoder: debounces 8 answer buttons and drives one active-low one-hot code per press.
// Latency: DEB_CYCLES+1 cycles from a clean raw press to hex_joy/sent; code held HOLD_CYCLES cycles.
// No backpressure: re-arms only after all buttons release; `define JOY_RR_ARB_EN for round-robin ties.
module joy_hex_encoder #(
   parameter int DEB_CYCLES  = 4,
   parameter int HOLD_CYCLES = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       arm,
   input  logic [3:0] btn_p1,
   input  logic [3:0] btn_p2,
   output logic [7:0] hex_joy,
   output logic       busy,
   output logic       sent
);

   localparam int CW = $clog2(DEB_CYCLES + 1);
   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DRIVE,
      S_RELEASE
   } state_t;

   logic [7:0]    raw;
   logic [7:0]    db_q, db_d;
   logic [7:0]    db_prev_q;
   logic [CW-1:0] cnt_q [8];
   logic [CW-1:0] cnt_d [8];
   logic [7:0]    new_edge;

   state_t        state_q, state_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [7:0]    hex_q, hex_d;
   logic          busy_q, busy_d;
   logic          sent_q, sent_d;
   logic          accept;

   logic          tie_to_p2;
   logic          pick_p2;
   logic [3:0]    sel;
   logic [1:0]    ans_idx;
   logic [7:0]    win_code;

   assign raw = {btn_p2, btn_p1};

   // A button's debounced state flips only after DEB_CYCLES consecutive disagreeing samples.
   always_comb begin
      db_d = db_q;
      for (int i = 0; i < 8; i++) begin
         cnt_d[i] = '0;
         if (raw[i] != db_q[i]) begin
            if (cnt_q[i] == DEB_LAST) begin
               db_d[i] = raw[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         db_q      <= '0;
         db_prev_q <= '0;
         for (int i = 0; i < 8; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         db_q      <= db_d;
         db_prev_q <= db_q;
         for (int i = 0; i < 8; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign new_edge = db_q & ~db_prev_q;

`ifdef JOY_RR_ARB_EN
   logic last_p2_q, last_p2_d;

   // Reset to "player 2 won last" so the first tie after reset favours player 1.
   always_comb begin
      last_p2_d = last_p2_q;
      if (accept) begin
         last_p2_d = pick_p2;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_p2_q <= 1'b1;
      end else begin
         last_p2_q <= last_p2_d;
      end
   end

   assign tie_to_p2 = ~last_p2_q;
`else
   assign tie_to_p2 = 1'b0;
`endif

   // Lowest answer wins within a player; code bit index is {player1, 3-answer}.
   always_comb begin
      pick_p2 = (new_edge[7:4] != 4'd0) && ((new_edge[3:0] == 4'd0) || tie_to_p2);
      sel     = pick_p2 ? new_edge[7:4] : new_edge[3:0];
      ans_idx = 2'd3;
      for (int i = 3; i >= 0; i--) begin
         if (sel[i]) begin
            ans_idx = 2'(i);
         end
      end
      win_code = 8'hFF;
      win_code[{~pick_p2, ~ans_idx}] = 1'b0;
   end

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      accept  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (arm && (new_edge != 8'd0)) begin
               accept  = 1'b1;
               state_d = S_DRIVE;
               hold_d  = HOLD_LAST;
            end
         end
         S_DRIVE: begin
            if (hold_q == '0) begin
               state_d = S_RELEASE;
            end else begin
               hold_d = hold_q - HW'(1);
            end
         end
         S_RELEASE: begin
            if (db_q == 8'd0) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Outputs are computed from the next state so they register alongside it.
      hex_d  = 8'hFF;
      if (accept) begin
         hex_d = win_code;
      end else if (state_d == S_DRIVE) begin
         hex_d = hex_q;
      end
      busy_d = (state_d != S_IDLE);
      sent_d = accept;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         hold_q  <= '0;
         hex_q   <= 8'hFF;
         busy_q  <= 1'b0;
         sent_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         hex_q   <= hex_d;
         busy_q  <= busy_d;
         sent_q  <= sent_d;
      end
   end

   assign hex_joy = hex_q;
   assign busy    = busy_q;
   assign sent    = sent_q;

   // At most one bit low, and a code only appears while busy.
   assert property (@(posedge clk) disable iff (rst) $onehot0(~hex_joy));
   assert property (@(posedge clk) disable iff (rst) (hex_joy != 8'hFF) |-> busy);
   assert property (@(posedge clk) disable iff (rst) sent |-> (hex_joy != 8'hFF));

endmodule

// File: tb/tb_joy_hex_encoder.sv
// Bench for joy_hex_encoder: press episodes push expected codes; a monitor checks each sent code.
module tb_joy_hex_encoder;

   localparam int DEB  = 4;
   localparam int HOLD = 8;
`ifdef JOY_RR_ARB_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   typedef struct {
      logic [7:0] code;
      int         edge_n;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       arm;
   logic [7:0] raw;
   logic [3:0] btn_p1, btn_p2;
   logic [7:0] hex_joy;
   logic       busy, sent;

   int   checks = 0;
   int   fails  = 0;
   int   edge_cnt = 0;
   bit   mon_en = 1'b0;
   bit   model_last_p2 = 1'b1;
   exp_t exp_q[$];

   assign btn_p1 = raw[3:0];
   assign btn_p2 = raw[7:4];

   joy_hex_encoder #(.DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD)) dut (
      .clk     (clk),
      .rst     (rst),
      .arm     (arm),
      .btn_p1  (btn_p1),
      .btn_p2  (btn_p2),
      .hex_joy (hex_joy),
      .busy    (busy),
      .sent    (sent)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Reference: winner is the lowest answer of the sole pressing player, or of the tie-break player.
   task automatic model_press(input logic [3:0] a1, input logic [3:0] a2, output logic [7:0] code);
      bit   p2;
      int   ans;
      logic [3:0] s;
      p2   = (a2 != 0) && ((a1 == 0) || (RR && !model_last_p2));
      s    = p2 ? a2 : a1;
      ans  = 0;
      while (!s[ans]) ans++;
      code = 8'hFF;
      code[p2 ? (3 - ans) : (7 - ans)] = 1'b0;
      if (RR) model_last_p2 = p2;
   endtask

   task automatic press_ep(input logic [3:0] b1, input logic [3:0] b2, input int hold,
                           input bit use_lit, input logic [7:0] lit);
      logic [7:0] m;
      exp_t e;
      model_press(b1, b2, m);
      e.code   = use_lit ? lit : m;
      e.edge_n = edge_cnt + DEB + 1;
      exp_q.push_back(e);
      arm = 1'b1;
      raw = {b2, b1};
      tick(hold);
      raw = '0;
      tick(DEB + HOLD + 4);
   endtask

   task automatic unarmed_ep(input logic [7:0] pat, input int hold0, input int hold1);
      arm = 1'b0;
      raw = pat;
      tick(hold0);
      arm = 1'b1;
      tick(hold1);
      raw = '0;
      tick(DEB + 4);
   endtask

   task automatic bounce_ep(input int idx, input int total, input int fixed_run);
      int   t;
      int   r;
      logic v;
      t = 0;
      v = 1'b1;
      arm = 1'b1;
      while (t < total) begin
         r = (fixed_run > 0) ? fixed_run : $urandom_range(1, DEB - 1);
         raw[idx] = v;
         tick(r);
         t += r;
         v = ~v;
      end
      raw = '0;
      tick(DEB + 2);
   endtask

   initial begin : monitor
      exp_t       e;
      bit         run;
      int         run_n;
      logic [7:0] cur;
      run   = 1'b0;
      run_n = 0;
      cur   = 8'hFF;
      forever begin
         @(negedge clk);
         if (!mon_en) begin
            run = 1'b0;
         end else if (run) begin
            if (hex_joy == cur) begin
               run_n++;
               chk("sent_single_pulse", sent, 1'b0);
               chk("busy_in_drive", busy, 1'b1);
            end else begin
               chk("hold_length", run_n, HOLD);
               chk("release_ff", hex_joy, 8'hFF);
               chk("release_busy", busy, 1'b1);
               run = 1'b0;
            end
         end else if (sent) begin
            if (exp_q.size() == 0) begin
               checks++;
               fails++;
               $display("FAIL unexpected_code: got %0h, expected no code (t=%0t)", hex_joy, $time);
            end else begin
               e = exp_q.pop_front();
               chk("code", hex_joy, e.code);
               chk("latency_edge", edge_cnt, e.edge_n);
            end
            cur   = hex_joy;
            run   = 1'b1;
            run_n = 1;
         end else begin
            chk("idle_ff", hex_joy, 8'hFF);
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached, %0d expected codes pending", exp_q.size());
      $fatal(1, "time limit");
   end

   initial begin : stimulus
      logic [7:0] pat;
      logic [7:0] m;
      exp_t       e;
      rst = 1'b0;
      arm = 1'b0;
      raw = '0;
      #1 rst = 1'b1;
      #3;
      chk("rst_hex", hex_joy, 8'hFF);
      chk("rst_busy", busy, 1'b0);
      chk("rst_sent", sent, 1'b0);
      tick(3);
      rst = 1'b0;
      tick(2);
      chk("post_rst_hex", hex_joy, 8'hFF);
      chk("post_rst_busy", busy, 1'b0);
      chk("post_rst_sent", sent, 1'b0);
      mon_en = 1'b1;

      // Cross-player ties straight after reset, then a long single press.
      press_ep(4'b0100, 4'b0010, 10, 1'b1, 8'b11011111);
      press_ep(4'b0100, 4'b0010, 10, 1'b1, RR ? 8'b11111011 : 8'b11011111);

      model_press(4'b0001, 4'b0000, m);
      e.code   = 8'b01111111;
      e.edge_n = edge_cnt + DEB + 1;
      exp_q.push_back(e);
      arm = 1'b1;
      raw = 8'h01;
      tick(30);
      raw = '0;
      tick(DEB);
      chk("busy_until_db_clear", busy, 1'b1);
      tick(1);
      chk("busy_clear_after_release", busy, 1'b0);
      tick(HOLD);

      press_ep(4'b1010, 4'b0000, 12, 1'b1, 8'b10111111);
      bounce_ep(7, 40, 2);
      unarmed_ep(8'h10, 8, 10);

      // Reset during the third DRIVE cycle, button still held afterwards.
      model_press(4'b0001, 4'b0000, m);
      e.code   = 8'b01111111;
      e.edge_n = edge_cnt + DEB + 1;
      exp_q.push_back(e);
      raw = 8'h01;
      tick(DEB + 3);
      #2;
      mon_en = 1'b0;
      rst = 1'b1;
      #1;
      chk("midrst_hex", hex_joy, 8'hFF);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_sent", sent, 1'b0);
      tick(2);
      rst = 1'b0;
      model_last_p2 = 1'b1;
      model_press(4'b0001, 4'b0000, m);
      e.code   = m;
      e.edge_n = edge_cnt + DEB + 1;
      exp_q.push_back(e);
      mon_en = 1'b1;
      tick(DEB + 4);
      raw = '0;
      tick(DEB + HOLD + 4);

      for (int n = 0; n < 30; n++) begin
         int kind;
         kind = $urandom_range(0, 9);
         pat  = 8'($urandom_range(1, 255));
         if (kind < 6) begin
            press_ep(pat[3:0], pat[7:4], $urandom_range(DEB, 30), 1'b0, 8'h00);
         end else if (kind < 8) begin
            unarmed_ep(pat, $urandom_range(DEB + 2, 12), $urandom_range(1, 10));
         end else begin
            bounce_ep($urandom_range(0, 7), $urandom_range(10, 40), 0);
         end
      end

      tick(10);
      chk("pending_codes", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/joy_hex_encoder.md
# joy_hex_encoder

Two-player answer-pad transmitter. It debounces eight raw push-buttons (four answers per player), picks a single winning press, and drives the 8-bit active-low one-hot answer bus (idle 8'hFF) that the game's answer/player decoder consumes. Each code is held for a fixed window. The block then re-arms only after every button is released, so each physical press yields exactly one code.

## Interface
Parameters:
- DEB_CYCLES, 4: consecutive stable samples required to change a debounced button state; minimum 1.
- HOLD_CYCLES, 8: cycles a code is driven on hex_joy; minimum 1.

Ports:
- clk, in, 1: single clock; all state changes on its rising edge.
- rst, in, 1: asynchronous, active-high reset.
- arm, in, 1: presses are accepted only in IDLE while arm=1.
- btn_p1, in, 4: player 1 raw buttons, active-high; bit0=answer 1 … bit3=answer 4.
- btn_p2, in, 4: player 2 raw buttons, same bit mapping as btn_p1.
- hex_joy, out, 8: active-low one-hot code; 8'hFF means no press.
- busy, out, 1: high in DRIVE and RELEASE.
- sent, out, 1: one-cycle pulse on the first DRIVE cycle.

## Operation
- Code map, where only the named bit is 0:
  - Player 1: answer 1→bit7, answer 2→bit6, answer 3→bit5, answer 4→bit4.
  - Player 2: answer 1→bit3, answer 2→bit2, answer 3→bit1, answer 4→bit0.
- Debounce is per button:
  - Each button has a counter of width clog2(DEB_CYCLES+1).
  - The counter increments while raw≠db and clears when raw==db.
  - When the count reaches DEB_CYCLES, db takes the raw value and the counter clears.
- Press detect: new = db & ~db_q, where db_q is db registered one cycle.
- FSM:
  - IDLE:
    - hex_joy=FF.
    - If arm and new≠0: latch the arbitrated winner, go to DRIVE, reload the hold counter to HOLD_CYCLES-1.
    - New edges in IDLE while arm=0 are discarded.
  - DRIVE:
    - hex_joy=code, busy=1.
    - Count down; at 0, go to RELEASE.
    - arm changes and new edges are ignored.
  - RELEASE:
    - hex_joy=FF, busy=1.
    - Stay until all 8 db bits are 0, then go to IDLE.
- Arbitration within a player: lowest answer number wins.
- Arbitration between players on a same-cycle tie: see Configuration. A single-player candidate always wins.
- All outputs are registered.
- Reset values: hex_joy=8'hFF, busy=0, sent=0, state=IDLE, all db/db_q/counters=0, last_winner=player 2.

## Timing
- Raw latency: a raw press stable from before edge 1 gives db=1 after edge DEB_CYCLES, and hex_joy low and sent=1 after edge DEB_CYCLES+1.
- Hold: hex_joy stays low for exactly HOLD_CYCLES cycles, then returns to FF for at least 1 cycle (RELEASE).
- Retrigger: earliest possible after all buttons release. Needs DEB_CYCLES cycles for db to clear, 1 cycle to reach IDLE, then a fresh debounced edge.
- Held buttons: a button held through DRIVE/RELEASE never retriggers. Its edge is consumed, and RELEASE blocks until it is released.
- Bouncing input: raw toggling with period ≤ DEB_CYCLES never changes db and produces no code.
- Reset mid-operation: asserting rst forces hex_joy=FF, busy=0, sent=0 immediately, without waiting for a clock edge. A button still held at deassertion gives db rising after DEB_CYCLES edges, which counts as a new press.

## Configuration
- JOY_RR_ARB_EN defined:
  - Cross-player ties go to the player that did not win last.
  - last_winner updates on every accepted press.
  - The first tie after reset goes to player 1.
- JOY_RR_ARB_EN undefined:
  - Player 1 always wins ties.
  - last_winner is not implemented.

## Test plan
All tests use DEB_CYCLES=4, HOLD_CYCLES=8.
- Reset: rst pulse with all buttons idle → hex_joy=8'hFF, busy=0, sent=0 during and after reset.
- Single press: arm=1, btn_p1[0] high for 30 cycles → after edge 5, hex_joy=8'b01111111 for 8 cycles with sent=1 on the first; then FF and busy=1 until release plus 4 cycles; no second code.
- Bounce: arm=1, btn_p2[3] toggled every 2 cycles for 40 cycles → hex_joy stays FF, sent never pulses.
- Same-player priority: btn_p1[1] and btn_p1[3] rise together → hex_joy=8'b10111111.
- Cross-player tie: btn_p1[2] and btn_p2[1] rise together, twice, with full release between.
  - With JOY_RR_ARB_EN: 8'b11011111, then 8'b11111011.
  - Without JOY_RR_ARB_EN: 8'b11011111 both times.
- Arm and reset:
  - btn_p2[0] pressed with arm=0 → no code.
  - Asserting arm while the button is still held → still no code, because the edge is gone.
  - rst asserted on the 3rd DRIVE cycle → hex_joy=FF immediately, busy=0.
